// File: rtl/pin_change_capture.sv
// Purpose: synchronise probe pins, timestamp every change, queue {pins, ts} records in a FWFT FIFO.
// Latency: push SYNC_STAGES cycles after sampling (+FILTER_CYCLES with PIN_GLITCH_FILTER_EN); head visible one cycle after push.
// Backpressure: out_valid/out_ready; when full a record is dropped and overflow sticks until overflow_clr.
// Optional glitch filter enabled by defining PIN_GLITCH_FILTER_EN.
module pin_change_capture #(
    parameter int WIDTH         = 8,
    parameter int TS_WIDTH      = 32,
    parameter int DEPTH         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            pin_values,
    output logic [WIDTH+TS_WIDTH-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic                        overflow,
    input  logic                        overflow_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = WIDTH + TS_WIDTH;

    // Reject configurations the pointer arithmetic and synchroniser cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_param_check
        $error("pin_change_capture: illegal parameter set");
    end

    logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]    synced;
    logic [WIDTH-1:0]    prev;
    logic [WIDTH-1:0]    nxt_prev;
    logic [TS_WIDTH-1:0] ts_cnt;
    logic                push_req;
    logic [DW-1:0]       push_rec;

    logic [DW-1:0]       mem [DEPTH];
    logic [AW:0]         wr_cnt;
    logic [AW:0]         rd_cnt;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;

    assign synced = sync_q[SYNC_STAGES-1];

    // Metastability chain for the asynchronous probe pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pin_values;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Free-running timestamp; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end

`ifdef PIN_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [WIDTH-1:0]    cand,    nxt_cand;
    logic [TS_WIDTH-1:0] cand_ts, nxt_cand_ts;
    logic [CW-1:0]       stab,    nxt_stab;
    logic                active,  nxt_active;

    // Candidate tracking: a change is only committed after it has held for FILTER_CYCLES cycles.
    always_comb begin
        push_req    = 1'b0;
        push_rec    = {cand, cand_ts};
        nxt_prev    = prev;
        nxt_cand    = cand;
        nxt_cand_ts = cand_ts;
        nxt_stab    = stab;
        nxt_active  = active;
        if (active && stab == CW'(FILTER_CYCLES)) begin
            push_req   = 1'b1;
            nxt_prev   = cand;
            nxt_active = 1'b0;
            nxt_stab   = '0;
        end else if (active) begin
            if (synced == prev) begin
                nxt_active = 1'b0;
                nxt_stab   = '0;
            end else if (synced != cand) begin
                nxt_cand    = synced;
                nxt_cand_ts = ts_cnt;
                nxt_stab    = CW'(1);
            end else begin
                nxt_stab = stab + CW'(1);
            end
        end else if (synced != prev) begin
            nxt_cand    = synced;
            nxt_cand_ts = ts_cnt;
            nxt_stab    = CW'(1);
            nxt_active  = 1'b1;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand    <= '0;
            cand_ts <= '0;
            stab    <= '0;
            active  <= 1'b0;
        end else begin
            cand    <= nxt_cand;
            cand_ts <= nxt_cand_ts;
            stab    <= nxt_stab;
            active  <= nxt_active;
        end
    end
`else
    // Every synchronised change becomes a record stamped with the current cycle.
    always_comb begin
        push_req = (synced != prev);
        push_rec = {synced, ts_cnt};
        nxt_prev = synced;
    end
`endif

    // Last committed pin value; tracks changes even when the record is dropped.
    always_ff @(posedge clk) begin
        if (rst) prev <= '0;
        else     prev <= nxt_prev;
    end

    assign fifo_level = wr_cnt - rd_cnt;
    assign out_valid  = (fifo_level != '0);
    assign full       = (fifo_level == (AW+1)'(DEPTH));
    assign pop        = out_valid & out_ready;
    assign push_ok    = push_req & (~full | pop);
    assign drop       = push_req & full & ~pop;
    assign out_data   = mem[rd_cnt[AW-1:0]];

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_cnt[AW-1:0]] <= push_rec;
    end

    // Write/read counters; their difference is the occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push_ok) wr_cnt <= wr_cnt + (AW+1)'(1);
            if (pop)     rd_cnt <= rd_cnt + (AW+1)'(1);
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear.
    always_ff @(posedge clk) begin
        if (rst)               overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end
endmodule

// File: tb/tb_pin_change_capture.sv
// Directed bench for pin_change_capture with a record scoreboard.
// Expected records are queued when a pin change is driven and compared at each pop.
// Filter-specific steps run only when PIN_GLITCH_FILTER_EN is defined.
module tb_pin_change_capture;
    localparam int W  = 8;
    localparam int TW = 32;
    localparam int D  = 16;
    localparam int DW = W + TW;
`ifdef PIN_GLITCH_FILTER_EN
    localparam int FC  = 4;
    localparam int GAP = 6;
`else
    localparam int FC  = 0;
    localparam int GAP = 1;
`endif
    localparam int LAT = 2 + FC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [W-1:0]      pin_values = '0;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [$clog2(D):0] fifo_level;
    logic              overflow;
    logic              overflow_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0]   tb_c;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    // Bench's own cycle count, zero in the first cycle after reset.
    always @(posedge clk) begin
        if (rst) tb_c <= '0;
        else     tb_c <= tb_c + 32'd1;
    end

    pin_change_capture #(
        .WIDTH(W), .TS_WIDTH(TW), .DEPTH(D), .SYNC_STAGES(2), .FILTER_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .pin_values(pin_values),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Change the pins in this cycle; optionally expect the record it produces.
    task automatic drive(input logic [W-1:0] v, input bit expect_rec);
        pin_values = v;
        if (expect_rec) exp_q.push_back({v, tb_c + 32'd2});
    endtask

    task automatic pop_one(input string tag);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_data"}, 64'(out_data), 64'(e));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_c(input logic [31:0] target);
        int n = 0;
        while (tb_c != target && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) chk("wait_timeout", 64'(tb_c), 64'(target));
    endtask

    initial begin
        // 1: reset and idle pins
        ticks(3);
        rst = 1'b0;
        ticks(5);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_level", 64'(fifo_level), 64'd0);
        chk("idle_ovf", 64'(overflow), 64'd0);

        // 2: single change at C=10, first-record latency
        wait_c(32'd10);
        drive(8'hD2, 1'b1);
        chk("t2_ts_model", 64'(exp_q[0]), 64'({8'hD2, 32'd12}));
        wait_c(32'd10 + 32'(LAT));
        chk("t2_valid_early", 64'(out_valid), 64'd0);
        tick();
        chk("t2_valid_rise", 64'(out_valid), 64'd1);
        chk("t2_level", 64'(fifo_level), 64'd1);
        pop_one("t2_pop");
        chk("t2_valid_after", 64'(out_valid), 64'd0);
        chk("t2_level_after", 64'(fifo_level), 64'd0);

        // 3: three changes 5 cycles apart, held without consumer
        drive(8'h2D, 1'b1); ticks(5);
        drive(8'hFF, 1'b1); ticks(5);
        drive(8'hD2, 1'b1); ticks(LAT + 2);
        chk("t3_level", 64'(fifo_level), 64'd3);
        ticks(3);
        chk("t3_level_hold", 64'(fifo_level), 64'd3);
        for (int i = 0; i < 3; i++) pop_one("t3_pop");
        chk("t3_empty", 64'(fifo_level), 64'd0);

        // 4: DEPTH+2 changes with no consumer -> overflow
        for (int i = 0; i < D + 2; i++) begin
            drive(W'(i), i < D);
            ticks(GAP);
        end
        ticks(LAT + 2);
        chk("t4_level_full", 64'(fifo_level), 64'(D));
        chk("t4_ovf_set", 64'(overflow), 64'd1);
        for (int i = 0; i < D; i++) pop_one("t4_pop");
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("t4_ovf_clr", 64'(overflow), 64'd0);

        // 5: full FIFO, push and pop land in the same cycle
        for (int i = 0; i < D; i++) begin
            drive(W'(8'h20 + i), 1'b1);
            ticks(GAP);
        end
        ticks(LAT + 2);
        chk("t5_level_full", 64'(fifo_level), 64'(D));
        drive(8'h55, 1'b1);
        ticks(LAT);
        begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            chk("t5_head", 64'(out_data), 64'(e));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_level_same", 64'(fifo_level), 64'(D));
        chk("t5_ovf_clear", 64'(overflow), 64'd0);
        for (int i = 0; i < D; i++) pop_one("t5_pop");
        chk("t5_empty", 64'(fifo_level), 64'd0);

        // Reset mid-operation flushes queued records
        drive(8'hA5, 1'b0);
        ticks(LAT + 2);
        chk("rst_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        pin_values = 8'h00;
        tick();
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        ticks(LAT + 4);
        chk("rst_no_push", 64'(fifo_level), 64'd0);

`ifdef PIN_GLITCH_FILTER_EN
        // 6: short pulse is filtered, stable change is recorded
        pin_values = 8'h01;
        ticks(2);
        pin_values = 8'h00;
        ticks(15);
        chk("t6_pulse_dropped", 64'(fifo_level), 64'd0);
        drive(8'h01, 1'b1);
        ticks(LAT + 2);
        chk("t6_level", 64'(fifo_level), 64'd1);
        pop_one("t6_pop");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
